// File: rtl/spi_host_pkg.sv
// Shared types and protocol constants for the SPI host master and its clients.
// The master itself is command-agnostic; the command bytes are for the client logic.
package spi_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam logic [7:0] CMD_LOAD_IMAGE   = 8'h00;
  localparam logic [7:0] CMD_START        = 8'hFF;
  localparam logic [7:0] CMD_COST         = 8'h01;
  localparam logic [7:0] RSP_NOT_READY    = 8'hFF;
  localparam int         LOAD_IMAGE_BYTES = 72;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period timer: counts CLK_DIV enabled cycles per phase and strobes
// o_rise / o_fall on the last cycle of a low / high phase.
module spi_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_phase;
  logic       w_tick;

  assign w_tick = i_en & ~i_clr & (r_cnt == LAST);
  assign o_rise = w_tick & ~r_phase;
  assign o_fall = w_tick & r_phase;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt   <= 8'd0;
      r_phase <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= 8'd0;
      r_phase <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt   <= 8'd0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_host_master.sv
// Byte-oriented SPI master (mode 0, LSB first) with held-SS bursts.
// Handshake: a request transfers on any rising edge where req_valid && req_ready.
module spi_host_master
  import spi_host_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_read,
  input  logic [7:0] req_data,
  input  logic       req_hold,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO,
  output state_t     dbg_state
);

  state_t     r_state;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic       r_read;
  logic       r_hold;
  logic [2:0] r_bit;
  logic       r_clr;
  logic       r_sck;
  logic       r_ss;
  logic       r_mosi;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;

  logic w_rise;
  logic w_fall;
  logic w_gen_en;
  logic w_accept;

  // Ready is a decode of the state register, held low while reset is asserted.
  assign req_ready = n_rst & ((r_state == ST_IDLE) | (r_state == ST_HOLD));
  assign w_accept  = req_valid & req_ready;
  assign w_gen_en  = (r_state == ST_SETUP) | (r_state == ST_HIGH) |
                     (r_state == ST_LOW)   | (r_state == ST_GAP);

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign SCK       = r_sck;
  assign SS        = r_ss;
  assign MOSI      = r_mosi;
  assign dbg_state = r_state;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_en   (w_gen_en),
    .i_clr  (r_clr),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_tx        <= 8'd0;
      r_rx        <= 8'd0;
      r_read      <= 1'b0;
      r_hold      <= 1'b0;
      r_bit       <= 3'd0;
      r_clr       <= 1'b0;
      r_sck       <= 1'b0;
      r_ss        <= 1'b1;
      r_mosi      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_clr       <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            r_tx    <= req_data;
            r_read  <= req_read;
            r_hold  <= req_hold;
            r_bit   <= 3'd0;
            // The timer stays cleared for the first SS-low cycle, giving SS one
            // cycle of lead before the SETUP half-period starts counting.
            r_clr   <= 1'b1;
            r_ss    <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= req_read | req_data[0];
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_rise) begin
            r_sck   <= 1'b1;
            r_rx    <= {MISO, r_rx[7:1]};
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_sck   <= 1'b0;
            r_tx    <= {1'b1, r_tx[7:1]};
            r_mosi  <= r_read | r_tx[1];
            r_state <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            if (r_bit == 3'd7) begin
              r_mosi <= 1'b1;
              if (r_read) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_rx;
              end
              if (r_hold) begin
                r_state <= ST_HOLD;
              end else begin
                r_ss    <= 1'b1;
                r_state <= ST_GAP;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_sck   <= 1'b1;
              r_rx    <= {MISO, r_rx[7:1]};
              r_state <= ST_HIGH;
            end
          end
        end
        ST_GAP: begin
          if (w_rise | w_fall) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master at CLK_DIV=4: vector table of single bytes
// plus hand-written back-to-back, burst, reset-abort and dropped-request sequences.
module tb_spi_host_master;
  import spi_host_pkg::*;

  localparam int DIV         = 4;
  localparam int SS_LOW_BYTE = 1 + 17 * DIV;

  logic       clk       = 1'b0;
  logic       n_rst     = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_read  = 1'b0;
  logic       req_hold  = 1'b0;
  logic [7:0] req_data  = 8'h00;
  logic       MISO      = 1'b1;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       SCK;
  logic       SS;
  logic       MOSI;
  state_t     dbg_state;

  always #5 clk = ~clk;

  spi_host_master #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_read  (req_read),
    .req_data  (req_data),
    .req_hold  (req_hold),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .SCK       (SCK),
    .SS        (SS),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Monitor / slave model state, sampled on the falling clk edge.
  int         rise_cnt = 0;
  int         ss_low_cnt = 0;
  int         rsp_cnt = 0;
  int         ss_fall_cnt = 0;
  int         ss_rise_cnt = 0;
  int         ss_high_run = 0;
  int         last_gap = 0;
  logic [7:0] cap_mosi = 8'h00;
  logic [7:0] last_rsp = 8'h00;
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] slave_idx = 3'd0;
  logic       prev_sck = 1'b0;
  logic       prev_ss = 1'b1;

  always @(negedge clk) begin
    if (SCK && !prev_sck) begin
      cap_mosi[rise_cnt[2:0]] = MOSI;
      rise_cnt  = rise_cnt + 1;
      slave_idx = slave_idx + 3'd1;
    end
    if (!SS) ss_low_cnt = ss_low_cnt + 1;
    if (SS && !prev_ss) ss_rise_cnt = ss_rise_cnt + 1;
    if (!SS && prev_ss) begin
      ss_fall_cnt = ss_fall_cnt + 1;
      last_gap    = ss_high_run;
    end
    ss_high_run = SS ? ss_high_run + 1 : 0;
    if (rsp_valid) begin
      rsp_cnt  = rsp_cnt + 1;
      last_rsp = rsp_data;
    end
    if (SS) slave_idx = 3'd0;
    MISO     = slave_byte[slave_idx];
    prev_sck = SCK;
    prev_ss  = SS;
  end

  typedef struct {
    logic       rd;
    logic [7:0] data;
    logic [7:0] miso;
    logic [7:0] exp_mosi;
    int         exp_rsp;
    logic [7:0] exp_rsp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    rise_cnt    = 0;
    ss_low_cnt  = 0;
    rsp_cnt     = 0;
    ss_fall_cnt = 0;
    ss_rise_cnt = 0;
    cap_mosi    = 8'h00;
  endtask

  task automatic start_req(input logic rd, input logic [7:0] data, input logic hold);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_read  = rd;
    req_data  = data;
    req_hold  = hold;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_state(input string name, input state_t s, input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (dbg_state != s && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(dbg_state), 32'(s));
  endtask

  initial begin
    int n;
    logic r;

    vecs[0] = '{1'b0, 8'hA5, 8'h00, 8'hA5, 0, 8'h00};
    vecs[1] = '{1'b1, 8'h00, 8'h3C, 8'hFF, 1, 8'h3C};
    vecs[2] = '{1'b0, 8'h5A, 8'hF0, 8'h5A, 0, 8'h3C};
    vecs[3] = '{1'b1, 8'h12, 8'hC3, 8'hFF, 1, 8'hC3};
    vecs[4] = '{1'b0, 8'h01, 8'hFF, 8'h01, 0, 8'hC3};
    vecs[5] = '{1'b1, 8'hFF, 8'h81, 8'hFF, 1, 8'h81};

    // Reset values while reset is held, then ready on the first free cycle.
    #2 n_rst = 1'b0;
    #1;
    check("rst_ss", {31'd0, SS}, 32'd1);
    check("rst_sck", {31'd0, SCK}, 32'd0);
    check("rst_mosi", {31'd0, MOSI}, 32'd1);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("rel_ready", {31'd0, req_ready}, 32'd1);
    check("rel_state", 32'(dbg_state), 32'(ST_IDLE));

    for (int i = 0; i < 6; i++) begin
      slave_byte = vecs[i].miso;
      clear_mon();
      start_req(vecs[i].rd, vecs[i].data, 1'b0);
      wait_state($sformatf("v%0d_done", i), ST_IDLE, 300);
      check($sformatf("v%0d_mosi", i), {24'd0, cap_mosi}, {24'd0, vecs[i].exp_mosi});
      check($sformatf("v%0d_rises", i), rise_cnt, 32'd8);
      check($sformatf("v%0d_ss_low", i), ss_low_cnt, SS_LOW_BYTE);
      check($sformatf("v%0d_rsp_cnt", i), rsp_cnt, vecs[i].exp_rsp);
      check($sformatf("v%0d_rsp_data", i), {24'd0, rsp_data}, {24'd0, vecs[i].exp_rsp_data});
      check($sformatf("v%0d_ss_idle", i), {31'd0, SS}, 32'd1);
    end
    check("last_rsp_seen", {24'd0, last_rsp}, 32'h81);

    // Back-to-back writes with req_valid held high across the gap.
    slave_byte = 8'h00;
    clear_mon();
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_hold  = 1'b0;
    req_data  = 8'h11;
    n = 0;
    for (int t = 0; t < 400 && n < 2; t++) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      #1;
      if (r) begin
        n++;
        req_data = 8'h22;
      end
    end
    req_valid = 1'b0;
    wait_state("b2b_done", ST_IDLE, 300);
    check("b2b_accepts", n, 32'd2);
    check("b2b_gap", last_gap, DIV + 1);
    check("b2b_ss_falls", ss_fall_cnt, 32'd2);
    check("b2b_rises", rise_cnt, 32'd16);
    check("b2b_mosi2", {24'd0, cap_mosi}, 32'h22);

    // Load-image burst: command plus 72 held bytes, SS low throughout.
    clear_mon();
    start_req(1'b0, CMD_LOAD_IMAGE, 1'b1);
    wait_state("burst_hold0", ST_HOLD, 300);
    check("hold_ss", {31'd0, SS}, 32'd0);
    check("hold_sck", {31'd0, SCK}, 32'd0);
    check("hold_mosi", {31'd0, MOSI}, 32'd1);
    check("hold_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < LOAD_IMAGE_BYTES; i++) begin
      start_req(1'b0, 8'(i * 3 + 1), (i != LOAD_IMAGE_BYTES - 1));
      if (i != LOAD_IMAGE_BYTES - 1) wait_state("burst_hold", ST_HOLD, 300);
      else wait_state("burst_end", ST_IDLE, 300);
    end
    check("burst_rises", rise_cnt, 32'd584);
    check("burst_ss_falls", ss_fall_cnt, 32'd1);
    check("burst_ss_rises", ss_rise_cnt, 32'd1);
    check("burst_rsp", rsp_cnt, 32'd0);
    check("burst_last_mosi", {24'd0, cap_mosi}, 32'hD6);

    // Reset during bit 3 of a write of 8'h00, then a clean byte.
    clear_mon();
    start_req(1'b0, 8'h00, 1'b0);
    for (int t = 0; t < 300 && rise_cnt < 4; t++) begin
      @(posedge clk);
      #1;
    end
    check("abort_bit3_sck", {31'd0, SCK}, 32'd1);
    check("abort_bit3_mosi", {31'd0, MOSI}, 32'd0);
    n_rst = 1'b0;
    #1;
    check("abort_ss", {31'd0, SS}, 32'd1);
    check("abort_sck", {31'd0, SCK}, 32'd0);
    check("abort_mosi", {31'd0, MOSI}, 32'd1);
    check("abort_ready", {31'd0, req_ready}, 32'd0);
    check("abort_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("abort_rel_ready", {31'd0, req_ready}, 32'd1);
    clear_mon();
    start_req(1'b0, 8'hC6, 1'b0);
    wait_state("clean_done", ST_IDLE, 300);
    check("clean_mosi", {24'd0, cap_mosi}, 32'hC6);
    check("clean_rises", rise_cnt, 32'd8);
    check("clean_ss_low", ss_low_cnt, SS_LOW_BYTE);

    // Requests pulsed mid-byte must be ignored.
    clear_mon();
    start_req(1'b0, 8'h96, 1'b0);
    wait_state("drop_high", ST_HIGH, 100);
    check("drop_ready_high", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_read  = 1'b1;
    req_data  = 8'h00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_state("drop_low", ST_LOW, 100);
    check("drop_ready_low", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_state("drop_done", ST_IDLE, 300);
    repeat (3) @(negedge clk);
    check("drop_mosi", {24'd0, cap_mosi}, 32'h96);
    check("drop_rises", rise_cnt, 32'd8);
    check("drop_ss_low", ss_low_cnt, SS_LOW_BYTE);
    check("drop_rsp", rsp_cnt, 32'd0);
    check("drop_ss_falls", ss_fall_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
